// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled, majority-vote UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_BREAK_DETECT_EN to add the sticky break_det output.

module uart_rx_fifo #(
    parameter int FREQ       = 100000000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_serial,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun_err,
    output logic                        frame_err,
    output logic                        parity_err,
    input  logic                        err_clear
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                        break_det
`endif
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int DIV_RAW = FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_LO     = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] OS_HI     = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Line synchroniser, post-reset settle counter and start-edge arming
    logic sync1_q, sync2_q;
    logic [1:0] settle_q, settle_d;
    logic armed_q, armed_d;
    logic rx_s;

    // Bit-recovery state
    state_e state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [OW-1:0] os_q, os_d, os_nx;
    logic [1:0] samp_q, samp_d;
    logic [BW-1:0] bit_q, bit_d;
    logic stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic par_bad_q, par_bad_d;
    logic ferr_q, ferr_d;
    logic low_q, low_d;
    logic done_q, done_d;
    logic tick, decide, bit_end, maj, par_calc;

    // FIFO and sticky flags
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
    logic good, brk_frame, frame_set, parity_set, overrun_set;
    logic push, pop, full;
`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q, brk_d;
`endif

    assign rx_s    = sync2_q;
    assign tick    = (div_q == DIV_LAST);
    assign os_nx   = os_q + OW'(1);
    assign decide  = tick && (state_q != S_IDLE) && (os_nx == OS_HI);
    assign bit_end = tick && (os_nx == '0);
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign par_calc = (^shift_q) ^ maj;

    // NOTE: every _d is given its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + DW'(1);
        os_d      = os_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        ferr_d    = ferr_q;
        low_d     = low_q;
        done_d    = 1'b0;
        armed_d   = armed_q;
        settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;

        if (tick && state_q != S_IDLE) begin
            os_d = os_nx;
            if (os_nx == OS_LO)  samp_d[0] = rx_s;
            if (os_nx == OS_MID) samp_d[1] = rx_s;
        end

        unique case (state_q)
            S_IDLE: begin
                // Arming needs a real high sample, so a line held low through reset is ignored
                if (settle_q == 2'd2) begin
                    if (!armed_q) begin
                        armed_d = rx_s;
                    end else if (!rx_s) begin
                        state_d   = S_START;
                        div_d     = '0;
                        os_d      = '0;
                        bit_d     = '0;
                        stop_d    = 1'b0;
                        shift_d   = '0;
                        par_bad_d = 1'b0;
                        ferr_d    = 1'b0;
                        low_d     = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    low_d   = low_q & ~maj;
                end
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_bad_d = (PARITY == 1) ? ~par_calc : par_calc;
                    low_d     = low_q & ~maj;
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (decide) begin
                    if (!maj) ferr_d = 1'b1;
                    low_d = low_q & ~maj;
                    // Leave mid-bit on the last stop so the next start edge is not missed
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (bit_end) begin
                    stop_d = stop_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef UART_RX_BREAK_DETECT_EN
        brk_frame = done_q & low_q;
`else
        brk_frame = 1'b0;
`endif
        good        = done_q & ~ferr_q & ~par_bad_q;
        frame_set   = done_q & ferr_q & ~brk_frame;
        parity_set  = done_q & par_bad_q & ~brk_frame;
        full        = (cnt_q == FULL_CNT);
        pop         = rx_valid & rx_ready;
        push        = good & (~full | pop);
        overrun_set = good & full & ~pop;

        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // A flag raised in the same cycle as err_clear survives
        ovr_d = (ovr_q & ~err_clear) | overrun_set;
        fe_d  = (fe_q & ~err_clear) | frame_set;
        pe_d  = (pe_q & ~err_clear) | parity_set;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_d = (brk_q & ~err_clear) | brk_frame;
`endif
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
            state_q   <= S_IDLE;
            div_q     <= '0;
            os_q      <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            ferr_q    <= 1'b0;
            low_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q     <= 1'b0;
`endif
        end else begin
            sync1_q   <= rx_serial;
            sync2_q   <= sync1_q;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            div_q     <= div_d;
            os_q      <= os_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            ferr_q    <= ferr_d;
            low_q     <= low_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q     <= brk_d;
`endif
        end
    end

    // NOTE: storage is deliberately not reset; rx_data is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= shift_q;
    end

    assign rx_valid    = (cnt_q != '0);
    assign rx_data     = rx_valid ? mem_q[rd_q] : '0;
    assign fifo_count  = cnt_q;
    assign overrun_err = ovr_q;
    assign frame_err   = fe_q;
    assign parity_err  = pe_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det   = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance (a) and an 8E2 instance (b), 160 clk per bit.

module tb_uart_rx_fifo;

    localparam int BIT_CYC = 160;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic err_clear = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b;
    logic [4:0] count_a, count_b;
    logic ovr_a, fe_a, pe_a, ovr_b, fe_b, pe_b;
`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_a, brk_b;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic exp_ovr_a = 1'b0;
    int lat;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .FREQ(1600000), .BAUDRATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_a (
        .clk(clk), .reset(reset), .rx_serial(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .fifo_count(count_a), .overrun_err(ovr_a), .frame_err(fe_a),
        .parity_err(pe_a), .err_clear(err_clear)
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_a)
`endif
    );

    uart_rx_fifo #(
        .FREQ(1600000), .BAUDRATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) u_dut_b (
        .clk(clk), .reset(reset), .rx_serial(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .fifo_count(count_b), .overrun_err(ovr_b), .frame_err(fe_b),
        .parity_err(pe_b), .err_clear(err_clear)
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else       rx_a = v;
    endtask

    function automatic logic cur_valid(input bit sel_b);
        return sel_b ? valid_b : valid_a;
    endfunction

    function automatic logic [7:0] cur_data(input bit sel_b);
        return sel_b ? data_b : data_a;
    endfunction

    function automatic int exp_size(input bit sel_b);
        return sel_b ? exp_b.size() : exp_a.size();
    endfunction

    // Instance b carries a parity bit and two stop bits; a glitch inverts one data bit for one cycle at its middle.
    task automatic send_frame(input bit sel_b, input logic [7:0] d, input logic par,
                              input logic stop2, input int glitch_bit);
        set_line(sel_b, 1'b0);
        cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            set_line(sel_b, d[i]);
            if (i == glitch_bit) begin
                cycles(BIT_CYC / 2);
                set_line(sel_b, ~d[i]);
                cycles(1);
                set_line(sel_b, d[i]);
                cycles(BIT_CYC / 2 - 1);
            end else begin
                cycles(BIT_CYC);
            end
        end
        if (sel_b) begin
            set_line(sel_b, par);
            cycles(BIT_CYC);
        end
        set_line(sel_b, 1'b1);
        cycles(BIT_CYC);
        if (sel_b) begin
            set_line(sel_b, stop2);
            cycles(BIT_CYC);
        end
        set_line(sel_b, 1'b1);
        cycles(20);
    endtask

    task automatic send_good(input bit sel_b, input logic [7:0] d, input int glitch_bit);
        if (exp_size(sel_b) < DEPTH) begin
            if (sel_b) exp_b.push_back(d);
            else       exp_a.push_back(d);
        end else if (!sel_b) begin
            exp_ovr_a = 1'b1;
        end
        send_frame(sel_b, d, ^d, 1'b1, glitch_bit);
    endtask

    task automatic drain(input bit sel_b, input string tag);
        logic [7:0] exp;
        while (exp_size(sel_b) > 0) begin
            int waited = 0;
            while (!cur_valid(sel_b) && waited < 50) begin
                cycles(1);
                waited++;
            end
            exp = sel_b ? exp_b.pop_front() : exp_a.pop_front();
            check({tag, "_valid"}, cur_valid(sel_b), 1);
            check({tag, "_data"}, cur_data(sel_b), exp);
            if (sel_b) ready_b = 1'b1;
            else       ready_a = 1'b1;
            cycles(1);
            ready_a = 1'b0;
            ready_b = 1'b0;
        end
        check({tag, "_empty"}, cur_valid(sel_b), 0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        cycles(1);
        err_clear = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(5);
        reset = 1'b1;
        check("rst_count_a", count_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_flags_a", {ovr_a, fe_a, pe_a}, 0);
        check("rst_count_b", count_b, 0);
        cycles(10);

        // Single 8N1 byte with latency window from the start edge
        exp_a.push_back(8'hA5);
        fork
            send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
            begin
                lat = 0;
                while (!valid_a && lat < 2000) begin
                    cycles(1);
                    lat++;
                end
            end
        join
        check("t1_latency_in_window", (lat >= 1510 && lat <= 1550), 1);
        check("t1_count", count_a, exp_a.size());
        check("t1_flags", {ovr_a, fe_a, pe_a}, 0);
        drain(1'b0, "t1");

        // Overrun: 17 bytes into 16 entries
        for (int b = 0; b <= 16; b++) send_good(1'b0, 8'(b), -1);
        check("t2_count", count_a, exp_a.size());
        check("t2_overrun", ovr_a, exp_ovr_a);
        check("t2_no_frame_err", fe_a, 0);
        drain(1'b0, "t2");
        pulse_clear();
        exp_ovr_a = 1'b0;
        check("t2_overrun_cleared", ovr_a, exp_ovr_a);

        // Even parity: bad then good
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, -1);
        check("t3_parity_err", pe_b, 1);
        check("t3_count_bad", count_b, 0);
        check("t3_no_frame_err", fe_b, 0);
        send_good(1'b1, 8'h03, -1);
        check("t3_count_good", count_b, exp_b.size());
        drain(1'b1, "t3");
        pulse_clear();
        check("t3_parity_cleared", pe_b, 0);

        // Second stop bit low
        send_frame(1'b1, 8'h81, 1'b0, 1'b0, -1);
        check("t4_frame_err", fe_b, 1);
        check("t4_count", count_b, 0);
        check("t4_no_parity_err", pe_b, 0);
        pulse_clear();
        check("t4_frame_cleared", fe_b, 0);

        // Short start glitch, then a majority-voted data glitch
        rx_a = 1'b0;
        cycles(40);
        rx_a = 1'b1;
        cycles(300);
        check("t5_glitch_count", count_a, 0);
        check("t5_glitch_flags", {ovr_a, fe_a, pe_a}, 0);
        send_good(1'b0, 8'h5A, 3);
        check("t5_vote_count", count_a, exp_a.size());
        check("t5_vote_flags", {ovr_a, fe_a, pe_a}, 0);
        drain(1'b0, "t5");

        // Whole-frame break
        rx_a = 1'b0;
        cycles(11 * BIT_CYC);
        rx_a = 1'b1;
        cycles(200);
        check("brk_count", count_a, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("brk_break_det", brk_a, 1);
        check("brk_frame_err", fe_a, 0);
`else
        check("brk_frame_err", fe_a, 1);
`endif
        pulse_clear();
        check("brk_cleared", fe_a, 0);

        // Reset mid-frame with 3 bytes buffered, line held low across reset release
        for (int k = 1; k <= 3; k++) send_good(1'b0, 8'(k * 17), -1);
        check("t6_count_before", count_a, exp_a.size());
        rx_a = 1'b0;
        cycles(500);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        exp_a.delete();
        check("t6_count_after_rst", count_a, 0);
        check("t6_valid_after_rst", valid_a, 0);
        cycles(300);
        rx_a = 1'b1;
        cycles(200);
        check("t6_no_spurious", count_a, 0);
        send_good(1'b0, 8'h3C, -1);
        check("t6_count_new", count_a, exp_a.size());
        drain(1'b0, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with oversampled majority-vote bit recovery, configurable frame format (data bits, parity, stop bits) and an integrated first-word-fall-through receive FIFO with a valid/ready pop interface. It sits between the board RX pin and the processor's memory-mapped UART peripheral. It is the next generation of the single-byte, single-register receiver, adding buffering, error reporting and format flexibility.

Parameters:
FREQ, 100000000, system clock frequency in Hz
BAUDRATE, 9600, line bit rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; allowed values 8 or 16
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame: 1 or 2
FIFO_DEPTH, 16, receive FIFO entries; power of 2, at least 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
rx_serial  in  1  asynchronous serial line; idles high
rx_data  out  DATA_BITS  FIFO head word, valid when rx_valid=1
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pop; pop occurs on rx_valid && rx_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overrun_err  out  1  sticky: a good frame was dropped because the FIFO was full
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
err_clear  in  1  single-cycle pulse clears all sticky error flags

Behaviour:
- Reset (reset=0 at a clk edge): FSM=IDLE, FIFO empty, rx_valid=0, rx_data=0, fifo_count=0, all error flags 0, tick counter 0, synchroniser flops preset to 1.
- rx_serial passes through a 2-flop synchroniser (preset 1). All decisions use the synchronised value.
- Tick generator: DIV = FREQ/(BAUDRATE*OVERSAMPLE), integer division. Counter runs 0..DIV-1 and emits a 1-cycle tick at wrap. It runs freely and is restarted to 0 when IDLE detects a falling edge.
- Bit sampling: the tick index within a bit runs 0..OVERSAMPLE-1. At indices OS/2-1, OS/2 and OS/2+1, the line is sampled. The bit value is the 2-of-3 majority, decided at index OS/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on synchronised 1->0 transition.
  - START: if the majority is 1, return to IDLE (glitch; no flag). Otherwise, at the end of the bit, go to DATA with bit index 0.
  - DATA: shift the majority bit into position [bit index], LSB first. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: compute even/odd over data bits plus the received parity bit; record a mismatch.
  - STOP: sample each of STOP_BITS stop bits; any low sample records a framing error. After the decision on the last stop bit, go to IDLE immediately (mid-bit) so that the next start edge is caught.
- Frame commit occurs one cycle after the last stop-bit decision:
  - frame_err or parity mismatch: set the corresponding sticky flag(s); discard the frame.
  - Good frame and FIFO not full, or full with a pop in the same cycle: push.
  - Good frame, FIFO full and no pop: drop the frame; set overrun_err.
- FIFO is first-word-fall-through.
  - rx_data reflects the head combinationally from registered storage.
  - A push into an empty FIFO gives rx_valid=1 on the next cycle.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
  - A pop on an empty FIFO is ignored.
- err_clear: clears the flags in the same edge. If a new error is set in the same cycle as err_clear, set wins.
- Reset mid-frame: the frame is abandoned and the FIFO is flushed. The receiver waits for a fresh falling edge; a line already low at reset release is not treated as a start until it returns high and falls again.

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined: adds output break_det (1 bit, sticky, cleared by err_clear). It is set when the line is sampled low for the whole frame: start, all data bits, parity and all stop bits. A break frame sets break_det instead of frame_err and is never pushed. The FSM then waits in IDLE for the line to go high before arming start detection.
- Not defined: no break_det port; a break is reported as frame_err only.

Test Plan:
1. FREQ=1600000, BAUDRATE=10000, OVERSAMPLE=16 (160 clk/bit), 8N1, send 0xA5 -> rx_valid=1 within 1530 +/-20 cycles of the start edge; rx_data=0xA5; fifo_count=1; no flags.
2. Same settings, rx_ready=0, send 17 bytes 0x00..0x10 into FIFO_DEPTH=16 -> fifo_count=16; overrun_err=1; popping yields 0x00..0x0F in order, then rx_valid=0.
3. PARITY=2 (even), send 0x03 with parity bit 1 -> parity_err=1; FIFO stays empty. Then send 0x03 with parity 0 -> rx_data=0x03.
4. STOP_BITS=2, second stop bit driven low -> frame_err=1, nothing pushed; err_clear pulse -> frame_err=0 next cycle.
5. A 40-cycle low glitch on an idle line -> back to IDLE, no push, no flags. A single-sample glitch at the mid-bit of a 0x5A data bit -> still received as 0x5A (majority vote).
6. reset=0 for 1 cycle mid-frame with 3 bytes buffered -> fifo_count=0, rx_valid=0; the next full frame 0x3C is received correctly.
